nibble_serial_adder: RTL and testbench
======================================

# nibble_serial_adder

Multi-cycle WIDTH-bit adder that time-shares one 4-bit `ripple_carry_adder` instance, processing one nibble per clock from LSB to MSB. A registered carry links the nibbles. Operands are accepted and results returned over valid/ready handshakes. It lets wide additions reuse the small 4-bit adder datapath at the cost of latency.

## Interface
- `WIDTH`, default 16: operand/result width; must be a multiple of 4 and ≥ 4.
- `NIBBLES`, derived as WIDTH/4: nibble steps per operation; not overridable.
- `clk`, in, 1: single clock; all state updates on rising edge.
- `rst_n`, in, 1: reset; asynchronous assert, active-low.
- `in_valid`, in, 1: operands `a`, `b`, `cin` are valid.
- `in_ready`, out, 1: block can accept operands.
- `a`, in, WIDTH: operand A.
- `b`, in, WIDTH: operand B.
- `cin`, in, 1: carry into nibble 0.
- `out_valid`, out, 1: `sum` and `cout` are valid.
- `out_ready`, in, 1: consumer accepts result.
- `sum`, out, WIDTH: a + b + cin, modulo 2^WIDTH.
- `cout`, out, 1: carry out of the MSB nibble.

## Operation
- FSM states:
  - IDLE: `in_ready`=1. When `in_valid` is high, latch `a`, `b` into operand registers, latch `cin` into `carry_q`, set `idx`=0, go to RUN.
  - RUN: the adder is fed `a_q[idx]`, `b_q[idx]`, `carry_q`.
    - Each cycle, write the adder's sum nibble into `sum_q[idx]` and its carry into `carry_q`.
    - If `idx`=NIBBLES-1: copy the carry into `cout_q` and go to DONE. Otherwise increment `idx`.
  - DONE: `out_valid`=1 and `sum`/`cout` are held stable. When `out_ready` is high, go to IDLE.
- `in_ready` is high only in IDLE; there is no overlap of operations.
- In RUN, `in_valid` is ignored and the operand registers are frozen.
- `idx` is `ceil(log2(NIBBLES))` bits wide. For WIDTH=4 it is a constant 0, and RUN lasts one cycle.
- Nibbles of `sum_q` not yet written in the current operation hold their previous values. `sum` is defined only while `out_valid`=1.
- Reset values:
  - state=IDLE.
  - `in_ready`=0; it is a registered output and rises on the first `clk` edge after `rst_n` deasserts.
  - `out_valid`=0, `sum`=0, `cout`=0, `idx`=0, `carry_q`=0.
- Reset asserted mid-RUN or mid-DONE: the operation is discarded and there is no partial result.

## Timing
- Accept edge T, where `in_valid` and `in_ready` are both high: nibble i is computed on edge T+1+i.
- `out_valid` goes high after edge T+NIBBLES (4 cycles for WIDTH=16).
- Result handshake on edge R: `out_valid` falls and `in_ready` rises after R. The next accept is possible at edge R+1.
- Minimum issue interval: NIBBLES+2 cycles.
- Outputs are registered and driven from the state and result registers only. There is no combinational path from `in_valid` or `out_ready` to any output.
- Critical path: one 4-bit ripple plus the nibble mux and demux.

## Structure
- Shared package/include `rca_pkg`:
  - `NIBBLE_W`=4.
  - State encodings: `S_IDLE`=2'd0, `S_RUN`=2'd1, `S_DONE`=2'd2.
  - Helper `clog2` function.
- One sub-module: the existing 4-bit `ripple_carry_adder`, instantiated once as `u_rca`. Port order is a, b, cin, carry, sum.
- Nibble select and writeback are done with indexed part-selects (`[idx*4 +: 4]`).

## Test plan
- Reset: with `rst_n`=0 → `out_valid`=0, `sum`=0, `cout`=0, `in_ready`=0. `in_ready`=1 one edge after release.
- a=0x0001, b=0x0001, cin=0 → `sum`=0x0002, `cout`=0. `out_valid` rises exactly 4 cycles after accept.
- a=0xFFFF, b=0x0001, cin=0 → `sum`=0x0000, `cout`=1. This checks the carry chain through all 4 nibbles.
- a=0xA5A5, b=0x5A5A, cin=1 → `sum`=0x0000, `cout`=1. Back-to-back issue: the second op a=0x1234, b=0x4321 accepted at R+1 → `sum`=0x5555, `cout`=0.
- Backpressure: hold `out_ready`=0 for 3 cycles in DONE → `sum`/`cout`/`out_valid` stable. `in_valid`=1 with a new operand is not accepted (`in_ready`=0) until after the result handshake.
- Reset mid-RUN after 2 nibbles → all outputs return to reset values with no `out_valid` pulse. Then a=0x00FF, b=0x0F01, cin=0 → `sum`=0x1000, `cout`=0.

Source files
------------

// File: rtl/rca_pkg.sv
// Shared constants, FSM state encoding and helpers for the nibble-serial adder.
package rca_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/nibble_serial_adder_if.sv
// Operand/result handshake bundle between a producer/consumer and the adder.
interface nibble_serial_adder_if #(
  parameter int WIDTH = 16
);
   // valid/ready: a transfer happens on a rising clk edge where both are high;
   // the sender holds its payload stable while valid is high and ready is low.
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;

   modport master (
      output in_valid, a, b, cin, out_ready,
      input  in_ready, out_valid, sum, cout
   );

   modport slave (
      input  in_valid, a, b, cin, out_ready,
      output in_ready, out_valid, sum, cout
   );

endinterface

// File: rtl/ripple_carry_adder.sv
// 4-bit ripple-carry adder built from a chain of full adders.
module ripple_carry_adder
   import rca_pkg::*;
(
   input  logic [NIBBLE_W-1:0] a,
   input  logic [NIBBLE_W-1:0] b,
   input  logic                cin,
   output logic                carry,
   output logic [NIBBLE_W-1:0] sum
);

   logic [NIBBLE_W:0] c;

   assign c[0] = cin;

   for (genvar i = 0; i < NIBBLE_W; i++) begin : g_fa
      assign sum[i]   = a[i] ^ b[i] ^ c[i];
      assign c[i+1]   = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
   end

   assign carry = c[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit adder that walks one shared 4-bit ripple adder across the operand
// nibbles, LSB first, with a registered carry between steps.
module nibble_serial_adder
   import rca_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   nibble_serial_adder_if.slave bus,
   output state_t               dbg_state
);

   localparam int NIBBLES = WIDTH / NIBBLE_W;
   // A single-nibble adder still needs a one-bit index; it simply stays at 0.
   localparam int IDX_W   = (NIBBLES > 1) ? clog2(NIBBLES) : 1;

   state_t             state_q;
   state_t             state_d;
   logic [WIDTH-1:0]   a_q;
   logic [WIDTH-1:0]   b_q;
   logic [WIDTH-1:0]   sum_q;
   logic               carry_q;
   logic               cout_q;
   logic [IDX_W-1:0]   idx_q;
   logic               in_ready_q;
   logic               out_valid_q;

   logic               accept;
   logic               last;
   logic [NIBBLE_W-1:0] a_nib;
   logic [NIBBLE_W-1:0] b_nib;
   logic [NIBBLE_W-1:0] rca_sum;
   logic               rca_carry;

   assign accept = bus.in_valid && in_ready_q;
   assign last   = (idx_q == IDX_W'(NIBBLES - 1));
   assign a_nib  = a_q[int'(idx_q) * NIBBLE_W +: NIBBLE_W];
   assign b_nib  = b_q[int'(idx_q) * NIBBLE_W +: NIBBLE_W];

   ripple_carry_adder u_rca (
      .a     (a_nib),
      .b     (b_nib),
      .cin   (carry_q),
      .carry (rca_carry),
      .sum   (rca_sum)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (accept) state_d = S_RUN;
         S_RUN:   if (last) state_d = S_DONE;
         S_DONE:  if (bus.out_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Handshake flags are registered from the next state so no input reaches
   // an output combinationally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         a_q         <= '0;
         b_q         <= '0;
         sum_q       <= '0;
         carry_q     <= 1'b0;
         cout_q      <= 1'b0;
         idx_q       <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         in_ready_q  <= (state_d == S_IDLE);
         out_valid_q <= (state_d == S_DONE);
         case (state_q)
            S_IDLE: begin
               if (accept) begin
                  a_q     <= bus.a;
                  b_q     <= bus.b;
                  carry_q <= bus.cin;
                  idx_q   <= '0;
               end
            end
            S_RUN: begin
               sum_q[int'(idx_q) * NIBBLE_W +: NIBBLE_W] <= rca_sum;
               carry_q <= rca_carry;
               if (last) begin
                  cout_q <= rca_carry;
               end else begin
                  idx_q <= idx_q + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.sum       = sum_q;
   assign bus.cout      = cout_q;
   assign dbg_state     = state_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench for nibble_serial_adder: directed corner cases plus random
// operands checked against plain a+b+cin arithmetic.
module tb_nibble_serial_adder;
  import rca_pkg::*;

  localparam int W       = 16;
  localparam int NIBBLES = W / 4;

  logic   clk;
  logic   rst_n;
  state_t dbg_state;

  nibble_serial_adder_if #(.WIDTH(W)) bus ();

  nibble_serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cycles = 0;
  always @(posedge clk) cycles++;

  // scoreboard state
  logic [W:0] exp_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  int  accept_cycle = 0;
  int  hs_cycle = 0;
  bit  prev_valid = 1'b0;
  bit  rand_rdy = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycles);
    end
  endtask

  function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
  endfunction

  // driver: present operands, wait (bounded) for the accept edge
  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc, input bit push);
    int n;
    n = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.a = ta;
    bus.b = tb;
    bus.cin = tc;
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      check("accept_timeout", 64'd0, 64'd1);
      bus.in_valid = 1'b0;
      return;
    end
    accept_cycle = cycles + 1;
    if (push) exp_q.push_back(ref_add(ta, tb, tc));
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid(input int budget);
    int n;
    n = 0;
    while (!bus.out_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!bus.out_valid) check("out_valid_timeout", 64'd0, 64'd1);
  endtask

  // monitor: pops on every result handshake, checks first-valid latency
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.out_valid && !prev_valid)
        check("latency", 64'(cycles - accept_cycle), 64'(NIBBLES));
      if (bus.out_valid && bus.out_ready) begin
        hs_cycle = cycles + 1;
        if (exp_q.size() == 0) begin
          check("unexpected_result", 64'd1, 64'd0);
        end else begin
          logic [W:0] e;
          e = exp_q.pop_front();
          check("result", 64'({bus.cout, bus.sum}), 64'(e));
        end
      end
      prev_valid = bus.out_valid;
    end else begin
      prev_valid = 1'b0;
    end
  end

  // random consumer backpressure
  initial begin
    forever begin
      @(posedge clk);
      if (rand_rdy) #1 bus.out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    logic [W-1:0] s_hold;
    logic         c_hold;
    int           n;

    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus.out_ready = 1'b1;
    rst_n         = 1'b0;

    // reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_sum", 64'(bus.sum), 64'd0);
    check("rst_cout", 64'(bus.cout), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd0);
    check("rst_state", 64'(dbg_state), 64'(S_IDLE));
    rst_n = 1'b1;
    @(negedge clk);
    check("in_ready_after_release", 64'(bus.in_ready), 64'd1);

    // directed operations
    send(16'h0001, 16'h0001, 1'b0, 1'b1);
    wait_valid(20);
    send(16'hFFFF, 16'h0001, 1'b0, 1'b1);
    wait_valid(20);
    send(16'hA5A5, 16'h5A5A, 1'b1, 1'b1);
    wait_valid(20);
    send(16'h1234, 16'h4321, 1'b0, 1'b1);
    check("back_to_back_accept", 64'(accept_cycle - hs_cycle), 64'd1);
    wait_valid(20);

    // backpressure: hold result, offer a new operand that must not be taken
    @(negedge clk);
    bus.out_ready = 1'b0;
    send(16'h0F0F, 16'h0101, 1'b1, 1'b1);
    wait_valid(20);
    s_hold = bus.sum;
    c_hold = bus.cout;
    check("bp_sum_value", 64'(s_hold), 64'h1011);
    bus.in_valid = 1'b1;
    bus.a = 16'h0003;
    bus.b = 16'h0004;
    bus.cin = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_out_valid", 64'(bus.out_valid), 64'd1);
      check("bp_sum_stable", 64'(bus.sum), 64'(s_hold));
      check("bp_cout_stable", 64'(bus.cout), 64'(c_hold));
      check("bp_in_ready", 64'(bus.in_ready), 64'd0);
    end
    bus.out_ready = 1'b1;
    send(16'h0003, 16'h0004, 1'b0, 1'b1);
    wait_valid(20);

    // reset in the middle of RUN, after two nibbles
    @(negedge clk);
    send(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    n = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.out_valid) n++;
    end
    check("midrun_no_valid", 64'(n), 64'd0);
    check("midrun_sum", 64'(bus.sum), 64'd0);
    check("midrun_cout", 64'(bus.cout), 64'd0);
    check("midrun_in_ready", 64'(bus.in_ready), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrun_in_ready_release", 64'(bus.in_ready), 64'd1);
    send(16'h00FF, 16'h0F01, 1'b0, 1'b1);
    wait_valid(20);

    // randomized traffic with random consumer stalls
    rand_rdy = 1'b1;
    for (int i = 0; i < 150; i++) begin
      send(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'b1);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(negedge clk);
    end
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    rand_rdy = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
